// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices,
// FSM encodings and the stall-bus width helper.
package pipeline_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_WAIT = 1'b1;

  function automatic int stall_bus_w(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Highest-set-bit to thermometer: bit k of the result is set when any
// request at index >= k-1 is set, so the requester and everything upstream hold.
module pipeline_ctrl_stall_encoder #(
  parameter int STAGES = 5
) (
  input  logic [STAGES-1:0] req,
  output logic [STAGES:0]   therm
);

  assign therm[0] = |req;

  genvar k;
  generate
    for (k = 1; k <= STAGES; k++) begin : g_therm
      assign therm[k] = |req[STAGES-1:k-1];
    end
  endgenerate

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: merges stage stall requests, owns the EX
// multi-cycle hold counter and registers flush requests into a redirect pulse.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STAGES   = 5,
  parameter int PC_W     = 32,
  parameter int MC_CNT_W = 6,
  parameter int EX_STAGE = STG_EX
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [STAGES-1:0]                stallreq,
  input  logic                             mc_start,
  input  logic [MC_CNT_W-1:0]              mc_cycles,
  input  logic                             mc_done,
  input  logic                             flush_req,
  input  logic [PC_W-1:0]                  flush_pc,
  output logic [stall_bus_w(STAGES)-1:0]   stall,
  output logic                             flush,
  output logic [PC_W-1:0]                  new_pc,
  output logic                             mc_busy
);

  localparam int SB = stall_bus_w(STAGES);

  logic [0:0]          state;
  logic [MC_CNT_W-1:0] remain;
  logic                hold;
  logic [STAGES-1:0]   mc_vec;
  logic [SB-1:0]       stall_req;
  logic [SB-1:0]       stall_mc;

  // The start cycle already counts as the first hold cycle.
  assign hold = (state == ST_RUN     && mc_start && mc_cycles != '0) ||
                (state == ST_MC_WAIT && !mc_done);

  // A hold looks like a request from EX, so the same encoder yields bits 0..EX_STAGE.
  assign mc_vec = hold ? (STAGES'(1) << (EX_STAGE - 1)) : '0;

  pipeline_ctrl_stall_encoder #(.STAGES(STAGES)) u_req_enc (
    .req  (stallreq),
    .therm(stall_req)
  );

  pipeline_ctrl_stall_encoder #(.STAGES(STAGES)) u_mc_enc (
    .req  (mc_vec),
    .therm(stall_mc)
  );

  // Combinational outputs are also masked by reset so they clear immediately.
  assign stall   = (!rst || flush) ? '0 : (stall_req | stall_mc);
  assign mc_busy = rst & hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      remain <= '0;
      flush  <= 1'b0;
      new_pc <= '0;
    end else begin
      flush <= flush_req;
      if (flush_req) new_pc <= flush_pc;

      if (flush_req) begin
        state  <= ST_RUN;
        remain <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (mc_start && mc_cycles > MC_CNT_W'(1)) begin
              state  <= ST_MC_WAIT;
              remain <= mc_cycles - MC_CNT_W'(1);
            end
          end
          default: begin
            // remain <= 1 also catches 0, so the decrement never wraps.
            if (mc_done || remain <= MC_CNT_W'(1)) begin
              state  <= ST_RUN;
              remain <= '0;
            end else begin
              remain <= remain - MC_CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (STAGES=5, EX_STAGE=3) with hand-computed expectations.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stallreq;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        mc_done;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.STAGES(5), .PC_W(32), .MC_CNT_W(6), .EX_STAGE(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .stallreq (stallreq),
    .mc_start (mc_start),
    .mc_cycles(mc_cycles),
    .mc_done  (mc_done),
    .flush_req(flush_req),
    .flush_pc (flush_pc),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .mc_busy  (mc_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stallreq = '0; mc_start = 0; mc_cycles = '0;
    mc_done = 0; flush_req = 0; flush_pc = '0;
    #2;
    chk("rst_stall", stall, 6'b000000);
    chk("rst_flush", flush, 1'b0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_busy", mc_busy, 1'b0);
    tick(); rst = 1'b1;

    // request merge, same-cycle response
    tick(); stallreq = 5'b00010; #2 chk("req_id", stall, 6'b000111);
    stallreq = 5'b00110; #1 chk("req_ex", stall, 6'b001111);
    stallreq = 5'b10000; #1 chk("req_wb", stall, 6'b111111);
    stallreq = 5'b00001; #1 chk("req_if", stall, 6'b000011);
    stallreq = 5'b00000; #1 chk("req_none", stall, 6'b000000);

    // 3-cycle hold
    tick(); mc_start = 1; mc_cycles = 6'd3; #2
    chk("mc3_t0_stall", stall, 6'b001111); chk("mc3_t0_busy", mc_busy, 1'b1);
    tick(); mc_start = 0; #2
    chk("mc3_t1_stall", stall, 6'b001111); chk("mc3_t1_busy", mc_busy, 1'b1);
    tick(); stallreq = 5'b10000; #2
    chk("mc3_t2_merge", stall, 6'b111111); chk("mc3_t2_busy", mc_busy, 1'b1);
    tick(); stallreq = '0; #2
    chk("mc3_t3_stall", stall, 6'b000000); chk("mc3_t3_busy", mc_busy, 1'b0);

    // zero-length and single-cycle ops
    tick(); mc_start = 1; mc_cycles = 6'd0; #2
    chk("mc0_stall", stall, 6'b000000); chk("mc0_busy", mc_busy, 1'b0);
    tick(); mc_cycles = 6'd1; #2
    chk("mc1_t0_stall", stall, 6'b001111); chk("mc1_t0_busy", mc_busy, 1'b1);
    tick(); mc_start = 0; #2
    chk("mc1_t1_stall", stall, 6'b000000); chk("mc1_t1_busy", mc_busy, 1'b0);

    // early completion; a second mc_start while waiting is ignored
    tick(); mc_start = 1; mc_cycles = 6'd10; #2 chk("done_t0_busy", mc_busy, 1'b1);
    tick(); mc_cycles = 6'd1; #2 chk("done_t1_busy", mc_busy, 1'b1);
    tick(); mc_start = 0; mc_done = 1; #2
    chk("done_t2_stall", stall, 6'b000000); chk("done_t2_busy", mc_busy, 1'b0);
    tick(); mc_done = 0; #2
    chk("done_t3_stall", stall, 6'b000000); chk("done_t3_busy", mc_busy, 1'b0);

    // flush during MC_WAIT with every stage requesting
    tick(); mc_start = 1; mc_cycles = 6'd8;
    tick(); mc_start = 0; stallreq = 5'b11111; flush_req = 1; flush_pc = 32'hBFC00380; #2
    chk("fl_t0_stall", stall, 6'b111111); chk("fl_t0_flush", flush, 1'b0);
    tick(); flush_req = 0; #2
    chk("fl_t1_flush", flush, 1'b1); chk("fl_t1_newpc", new_pc, 32'hBFC00380);
    chk("fl_t1_stall", stall, 6'b000000); chk("fl_t1_busy", mc_busy, 1'b0);
    tick(); #2
    chk("fl_t2_flush", flush, 1'b0); chk("fl_t2_newpc", new_pc, 32'hBFC00380);
    chk("fl_t2_stall", stall, 6'b111111); chk("fl_t2_busy", mc_busy, 1'b0);
    stallreq = '0;

    // back-to-back flush
    tick(); flush_req = 1; flush_pc = 32'h1000;
    tick(); flush_pc = 32'h2000; #2
    chk("b2b_t1_flush", flush, 1'b1); chk("b2b_t1_newpc", new_pc, 32'h1000);
    tick(); flush_req = 0; #2
    chk("b2b_t2_flush", flush, 1'b1); chk("b2b_t2_newpc", new_pc, 32'h2000);
    tick(); #2
    chk("b2b_t3_flush", flush, 1'b0); chk("b2b_t3_newpc", new_pc, 32'h2000);

    // mc_start together with flush_req: stalls now, no hold afterwards
    tick(); flush_req = 1; flush_pc = 32'h3000; mc_start = 1; mc_cycles = 6'd5; #2
    chk("fmc_t0_stall", stall, 6'b001111); chk("fmc_t0_busy", mc_busy, 1'b1);
    tick(); flush_req = 0; mc_start = 0; #2
    chk("fmc_t1_stall", stall, 6'b000000); chk("fmc_t1_busy", mc_busy, 1'b0);
    chk("fmc_t1_newpc", new_pc, 32'h3000);
    tick(); #2
    chk("fmc_t2_stall", stall, 6'b000000); chk("fmc_t2_busy", mc_busy, 1'b0);

    // async reset mid-hold (remain=4)
    tick(); mc_start = 1; mc_cycles = 6'd6;
    tick(); mc_start = 0;
    tick(); stallreq = 5'b00100; #1
    chk("pre_rst_busy", mc_busy, 1'b1);
    rst = 1'b0; #1
    chk("arst_stall", stall, 6'b000000); chk("arst_busy", mc_busy, 1'b0);
    chk("arst_flush", flush, 1'b0); chk("arst_newpc", new_pc, 32'h0);
    tick(); rst = 1'b1; stallreq = '0; #2
    chk("post_rst_busy", mc_busy, 1'b0); chk("post_rst_stall", stall, 6'b000000);
    tick(); #2
    chk("post_rst2_busy", mc_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
